// File: rtl/ram_pkg.sv
// Shared encodings and lane helpers for the unified instruction/data RAM.
package ram_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    MEM_DISABLE   = 2'b00,
    MEM_READ_SEXT = 2'b01,
    MEM_READ_ZEXT = 2'b10,
    MEM_WRITE     = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALFWORD  = 2'b01,
    WORD      = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  // Load formatting info carried alongside the RAM read latency.
  typedef struct packed {
    logic      sext;
    mem_size_e size;
    logic [1:0] off;
  } ld_ctrl_t;

  // Naturally aligned accesses only; the reserved size is never legal.
  function automatic logic is_aligned(input mem_size_e size, input logic [1:0] off);
    logic ok;
    case (size)
      BYTE:     ok = 1'b1;
      HALFWORD: ok = ~off[0];
      WORD:     ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [NUM_LANES-1:0] lane_mask(input mem_size_e size, input logic [1:0] off);
    logic [NUM_LANES-1:0] m;
    case (size)
      BYTE:     m = 4'b0001 << off;
      HALFWORD: m = off[1] ? 4'b1100 : 4'b0011;
      WORD:     m = 4'b1111;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  // Pick the addressed field out of a little-endian word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input ld_ctrl_t c);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (c.off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = c.off[1] ? word[31:16] : word[15:0];
    case (c.size)
      BYTE:     r = {{24{c.sext & b[7]}}, b};
      HALFWORD: r = {{16{c.sext & h[15]}}, h};
      default:  r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_top_dp_bram_be.sv
// True dual-port RAM: port A read-only, port B read/write with byte enables.
// Both ports have registered, read-first outputs that hold when not enabled.
module dp_bram_be
  import ram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en_a,
  input  logic [AW-1:0]                       addr_a,
  output logic [31:0]                         q_a,
  input  logic                                en_b,
  input  logic [NUM_LANES-1:0]                we_b,
  input  logic [AW-1:0]                       addr_b,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]    d_b,
  output logic [31:0]                         q_b
);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH];
  logic [31:0] q_a_d, q_a_q, q_b_d, q_b_q;

  // Byte-lane writes; storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (en_b) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we_b[i]) mem[addr_b][i] <= d_b[i];
      end
    end
  end

  // Next read data: old word on enable (read-first), otherwise hold.
  always_comb begin
    q_a_d = en_a ? mem[addr_a] : q_a_q;
    q_b_d = en_b ? mem[addr_b] : q_b_q;
  end

  // Output registers, cleared by reset so the block's outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: rtl/ram_top.sv
// Unified instruction/data RAM: word fetch port A, load/store port B.
module ram_top
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrAddr,
  input  logic        enA,
  input  logic [31:0] alu,
  input  logic [31:0] din,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  output logic [31:0] doutA,
  output logic [31:0] addrAOut,
  output logic        readValidA,
  output logic [31:0] doutB,
  output logic [31:0] addrBOut,
  output logic        readValidB,
  output logic        ready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_op_e   op;
  mem_size_e sz;
  assign op = mem_op_e'(memOp);
  assign sz = mem_size_e'(memSize);

  logic                             ready_d, ready_q;
  logic                             vld_a_d, vld_a_q, vld_b_d, vld_b_q;
  logic [31:0]                      addr_a_d, addr_a_q, addr_b_d, addr_b_q;
  ld_ctrl_t                         ld_d, ld_q;
  logic                             aligned, rd_b, wr_b, en_a;
  logic [NUM_LANES-1:0]             be;
  logic [NUM_LANES-1:0][LANE_W-1:0] wdata;
  logic [31:0]                      q_a, q_b;

  // Request qualification, byte enables and store-lane replication.
  always_comb begin
    aligned = is_aligned(sz, alu[1:0]);
    rd_b    = ready_q && aligned && (op == MEM_READ_SEXT || op == MEM_READ_ZEXT);
    wr_b    = ready_q && aligned && (op == MEM_WRITE);
    en_a    = ready_q && enA;
    be      = lane_mask(sz, alu[1:0]) & {NUM_LANES{wr_b}};
    case (sz)
      BYTE:     wdata = {NUM_LANES{din[7:0]}};
      HALFWORD: wdata = {2{din[15:0]}};
      default:  wdata = din;
    endcase
  end

  // Pipeline state next values; address/format only advance on a real read.
  always_comb begin
    ready_d  = 1'b1;
    vld_a_d  = en_a;
    addr_a_d = en_a ? instrAddr : addr_a_q;
    vld_b_d  = rd_b;
    addr_b_d = rd_b ? alu : addr_b_q;
    ld_d     = ld_q;
    if (rd_b) begin
      ld_d.sext = (op == MEM_READ_SEXT);
      ld_d.size = sz;
      ld_d.off  = alu[1:0];
    end
  end

  // Valid/address pipeline and the ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      ld_q     <= '0;
    end else begin
      ready_q  <= ready_d;
      vld_a_q  <= vld_a_d;
      vld_b_q  <= vld_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      ld_q     <= ld_d;
    end
  end

  dp_bram_be #(.DEPTH(DEPTH_WORDS)) u_bram (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_a   (en_a),
    .addr_a (instrAddr[AW+1:2]),
    .q_a    (q_a),
    .en_b   (rd_b | wr_b),
    .we_b   (be),
    .addr_b (alu[AW+1:2]),
    .d_b    (wdata),
    .q_b    (q_b)
  );

  assign doutA      = q_a;
  assign addrAOut   = addr_a_q;
  assign readValidA = vld_a_q;
  assign doutB      = load_extend(q_b, ld_q);
  assign addrBOut   = addr_b_q;
  assign readValidB = vld_b_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_ram_top.sv
// Self-checking bench for ram_top: directed scenarios plus a randomized run
// against a byte-array memory model.
module tb_ram_top;

  localparam int DEPTH = 4096;
  localparam logic [31:0] AMASK = DEPTH * 4 - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instrAddr = '0, alu = '0, din = '0;
  logic        enA = 1'b0;
  logic [1:0]  memOp = 2'b00, memSize = 2'b00;
  logic [31:0] doutA, addrAOut, doutB, addrBOut;
  logic        readValidA, readValidB, ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mm [DEPTH*4];

  ram_top #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .instrAddr(instrAddr), .enA(enA), .alu(alu),
    .din(din), .memOp(memOp), .memSize(memSize), .doutA(doutA),
    .addrAOut(addrAOut), .readValidA(readValidA), .doutB(doutB),
    .addrBOut(addrBOut), .readValidB(readValidB), .ready(ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
  endfunction

  function automatic bit m_ok(input logic [31:0] a, input logic [1:0] size);
    int n = nbytes(size);
    return (n != 0) && ((a % n) == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int n, input bit sext);
    logic [31:0] v = '0;
    int base = int'(a & AMASK);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[base + i];
    if (sext && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 1);
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input int n, input logic [31:0] d);
    int base = int'(a & AMASK);
    for (int i = 0; i < n; i++) mm[base + i] = d[8*i +: 8];
  endtask

  // ---------------- drivers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [1:0] op, input logic [1:0] size,
                         input logic [31:0] a, input logic [31:0] d);
    memOp = op; memSize = size; alu = a; din = d;
  endtask

  task automatic idle();
    enA = 1'b0; memOp = 2'b00;
  endtask

  task automatic wr(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
    drive_b(2'b11, size, a, d);
    if (m_ok(a, size)) m_store(a, nbytes(size), d);
    cycle();
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    n_tests++;
    if ({doutA, doutB, addrAOut, addrBOut, readValidA, readValidB, ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got A=%h B=%h aA=%h aB=%h vA=%b vB=%b rdy=%b, want all 0",
                         doutA, doutB, addrAOut, addrBOut, readValidA, readValidB, ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enA = 1'b1; instrAddr = 32'h0;
    #1;
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", ready); end
    cycle();
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", ready); end
    n_tests++;
    if (readValidA !== 1'b0) begin n_fail++; $display("FAIL fetch_while_not_ready: readValidA=%b want 0", readValidA); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] vals  [3];
    addrs = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    vals  = '{32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h1234_5678};
    for (int i = 0; i < 3; i++) begin
      wr(2'b10, addrs[i], vals[i]);
      n_tests++;
      if (readValidB !== 1'b0) begin n_fail++; $display("FAIL valid_after_write%0d: got %b want 0", i, readValidB); end
    end
    for (int i = 0; i < 3; i++) begin
      drive_b(2'b10, 2'b10, addrs[i], 32'hx);
      cycle();
      n_tests++;
      if ({readValidB, addrBOut, doutB} !== {1'b1, addrs[i], vals[i]}) begin
        n_fail++; $display("FAIL b2b_read%0d: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                           i, readValidB, addrBOut, doutB, addrs[i], vals[i]);
      end
    end
    idle();
  endtask

  task automatic test_write_then_read();
    wr(2'b10, 32'h8000_0014, 32'h1234_5678);
    drive_b(2'b10, 2'b10, 32'h8000_0014, 32'h0);
    cycle();
    n_tests++;
    if (doutB !== 32'h1234_5678 || readValidB !== 1'b1) begin
      n_fail++; $display("FAIL write_then_read: got %h v=%b want 12345678 v=1", doutB, readValidB);
    end
    idle();
  endtask

  task automatic test_half_byte();
    wr(2'b01, 32'h20, 32'hAAAA_8765);
    drive_b(2'b10, 2'b01, 32'h20, 32'h0); cycle();
    n_tests++;
    if (doutB !== 32'h0000_8765) begin n_fail++; $display("FAIL half_zext: got %h want 00008765", doutB); end
    drive_b(2'b01, 2'b01, 32'h20, 32'h0); cycle();
    n_tests++;
    if (doutB !== 32'hFFFF_8765) begin n_fail++; $display("FAIL half_sext: got %h want ffff8765", doutB); end
    wr(2'b00, 32'h30, 32'h1234_56FE);
    drive_b(2'b10, 2'b00, 32'h30, 32'h0); cycle();
    n_tests++;
    if (doutB !== 32'h0000_00FE) begin n_fail++; $display("FAIL byte_zext: got %h want 000000fe", doutB); end
    idle();
  endtask

  task automatic test_sext_bytes();
    logic [31:0] exp [4];
    exp = '{32'hFFFF_FFFE, 32'hFFFF_FFCA, 32'hFFFF_FFAD, 32'h0000_000E};
    wr(2'b10, 32'h60, 32'h0EAD_CAFE);
    for (int i = 0; i < 4; i++) begin
      drive_b(2'b01, 2'b00, 32'h60 + i, 32'h0);
      cycle();
      n_tests++;
      if (doutB !== exp[i]) begin n_fail++; $display("FAIL sext_byte%0d: got %h want %h", i, doutB, exp[i]); end
    end
    idle();
  endtask

  task automatic test_port_a_alias();
    enA = 1'b1; instrAddr = 32'h8000_0000; cycle();
    n_tests++;
    if ({readValidA, addrAOut, doutA} !== {1'b1, 32'h8000_0000, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL fetch0: got v=%b a=%h d=%h want v=1 a=80000000 d=deadbeef", readValidA, addrAOut, doutA);
    end
    instrAddr = 32'h8000_0004; cycle();
    n_tests++;
    if ({readValidA, addrAOut, doutA} !== {1'b1, 32'h8000_0004, 32'hCAFE_BABE}) begin
      n_fail++; $display("FAIL fetch4: got v=%b a=%h d=%h want v=1 a=80000004 d=cafebabe", readValidA, addrAOut, doutA);
    end
    enA = 1'b0; instrAddr = 32'h0; cycle();
    n_tests++;
    if ({readValidA, addrAOut, doutA} !== {1'b0, 32'h8000_0004, 32'hCAFE_BABE}) begin
      n_fail++; $display("FAIL fetch_hold: got v=%b a=%h d=%h want v=0 a=80000004 d=cafebabe", readValidA, addrAOut, doutA);
    end
    enA = 1'b1; instrAddr = 32'h8000_0060;
    drive_b(2'b10, 2'b10, 32'h0000_0004, 32'h0); cycle();
    n_tests++;
    if (doutA !== 32'h0EAD_CAFE || doutB !== 32'hCAFE_BABE) begin
      n_fail++; $display("FAIL alias: got A=%h B=%h want A=0eadcafe B=cafebabe", doutA, doutB);
    end
    // same-edge fetch and store to one word: fetch sees the old word
    instrAddr = 32'h0000_0008;
    drive_b(2'b11, 2'b10, 32'h8000_0008, 32'h1111_2222);
    m_store(32'h8, 4, 32'h1111_2222);
    cycle();
    n_tests++;
    if (doutA !== 32'h1234_5678) begin n_fail++; $display("FAIL read_first: got %h want 12345678", doutA); end
    memOp = 2'b00; cycle();
    n_tests++;
    if (doutA !== 32'h1111_2222) begin n_fail++; $display("FAIL fetch_new: got %h want 11112222", doutA); end
    idle();
  endtask

  task automatic test_misaligned();
    wr(2'b01, 32'h21, 32'h0000_BEEF);
    n_tests++;
    if (readValidB !== 1'b0) begin n_fail++; $display("FAIL misaligned_write_valid: got %b want 0", readValidB); end
    wr(2'b10, 32'h62, 32'h5555_5555);
    wr(2'b11, 32'h30, 32'h0000_0011);
    drive_b(2'b10, 2'b01, 32'h20, 32'h0); cycle();
    n_tests++;
    if (doutB !== 32'h0000_8765) begin n_fail++; $display("FAIL misaligned_half_ignored: got %h want 00008765", doutB); end
    drive_b(2'b10, 2'b10, 32'h60, 32'h0); cycle();
    n_tests++;
    if (doutB !== 32'h0EAD_CAFE) begin n_fail++; $display("FAIL misaligned_word_ignored: got %h want 0eadcafe", doutB); end
    drive_b(2'b10, 2'b00, 32'h30, 32'h0); cycle();
    n_tests++;
    if (doutB !== 32'h0000_00FE) begin n_fail++; $display("FAIL reserved_write_ignored: got %h want 000000fe", doutB); end
    drive_b(2'b10, 2'b10, 32'h61, 32'h0); cycle();
    n_tests++;
    if (readValidB !== 1'b0) begin n_fail++; $display("FAIL misaligned_read_valid: got %b want 0", readValidB); end
    drive_b(2'b01, 2'b11, 32'h60, 32'h0); cycle();
    n_tests++;
    if (readValidB !== 1'b0) begin n_fail++; $display("FAIL reserved_read_valid: got %b want 0", readValidB); end
    idle(); cycle();
    n_tests++;
    if (readValidB !== 1'b0) begin n_fail++; $display("FAIL disable_valid: got %b want 0", readValidB); end
  endtask

  task automatic test_random();
    logic [31:0] exp_a, exp_aa, exp_b, exp_ba, a;
    logic        exp_va, exp_vb, have_a;
    logic [1:0]  op, sz;
    int          rnd_fail;
    // seed a 256-byte window so every random read hits known data
    for (int i = 0; i < 64; i++) wr(2'b10, 32'h200 + 4*i, $urandom);
    have_a = 1'b0; exp_a = '0; exp_aa = '0;
    rnd_fail = 0;
    for (int c = 0; c < 300; c++) begin
      enA       = 1'($urandom_range(0, 1));
      instrAddr = ($urandom & 32'hFFFF_C000) | 32'h200 | $urandom_range(0, 255);
      op        = 2'($urandom_range(0, 3));
      sz        = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sz = 2'b11;
      else if (sz == 2'b11) sz = 2'b10;
      a         = ($urandom & 32'hFFFF_C000) | 32'h200 | $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      drive_b(op, sz, a, $urandom);
      exp_va = enA;
      if (enA) begin
        exp_a = m_load(instrAddr & ~32'h3, 4, 1'b0); exp_aa = instrAddr; have_a = 1'b1;
      end
      exp_vb = (op == 2'b01 || op == 2'b10) && m_ok(a, sz);
      exp_b  = exp_vb ? m_load(a, nbytes(sz), op == 2'b01) : 32'h0;
      exp_ba = a;
      if (op == 2'b11 && m_ok(a, sz)) m_store(a, nbytes(sz), din);
      cycle();
      n_tests++;
      if (readValidA !== exp_va || (have_a && (doutA !== exp_a || addrAOut !== exp_aa))) begin
        n_fail++; rnd_fail++;
        if (rnd_fail < 5) $display("FAIL rand_portA c%0d: got v=%b a=%h d=%h want v=%b a=%h d=%h",
                                   c, readValidA, addrAOut, doutA, exp_va, exp_aa, exp_a);
      end
      n_tests++;
      if (readValidB !== exp_vb || (exp_vb && (doutB !== exp_b || addrBOut !== exp_ba))) begin
        n_fail++; rnd_fail++;
        if (rnd_fail < 5) $display("FAIL rand_portB c%0d: got v=%b a=%h d=%h want v=%b a=%h d=%h",
                                   c, readValidB, addrBOut, doutB, exp_vb, exp_ba, exp_b);
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    enA = 1'b1; instrAddr = 32'h0; drive_b(2'b10, 2'b10, 32'h4, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0; idle();
    #1;
    n_tests++;
    if ({doutA, doutB, addrAOut, addrBOut, readValidA, readValidB, ready} !== '0) begin
      n_fail++; $display("FAIL midreset_async: got A=%h B=%h aA=%h aB=%h vA=%b vB=%b rdy=%b, want all 0",
                         doutA, doutB, addrAOut, addrBOut, readValidA, readValidB, ready);
    end
    cycle(); cycle();
    n_tests++;
    if ({doutA, doutB, addrAOut, addrBOut, readValidA, readValidB, ready} !== '0) begin
      n_fail++; $display("FAIL midreset_held: got A=%h B=%h vA=%b vB=%b rdy=%b, want all 0",
                         doutA, doutB, readValidA, readValidB, ready);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready_low: got %b want 0", ready); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_tests++;
      if ({ready, readValidA, readValidB} !== 3'b100) begin
        n_fail++; $display("FAIL midreset_release%0d: got rdy=%b vA=%b vB=%b want 1 0 0", i, ready, readValidA, readValidB);
      end
    end
    drive_b(2'b10, 2'b10, 32'h8000_0000, 32'h0); cycle();
    n_tests++;
    if (doutB !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_survives_reset: got %h want deadbeef", doutB); end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write_then_read();
    test_half_byte();
    test_sext_bytes();
    test_port_a_alias();
    test_misaligned();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
